// File: rtl/prog_delay_line_pkg.sv
// rtl/prog_delay_line_pkg.sv - shared types, reset constants and sizing helper for prog_delay_line
package prog_delay_line_pkg;

   typedef enum logic [1:0] {
      FLUSH = 2'd0,
      FILL  = 2'd1,
      RUN   = 2'd2
   } state_e;

   localparam int DEFAULT_WIDTH     = 8;
   localparam int DEFAULT_MAX_DEPTH = 16;

   localparam state_e RST_STATE = FLUSH;
   localparam logic   RST_VALID = 1'b0;
   localparam logic   RST_BUSY  = 1'b1;

   // Pointer width for a ring of the given depth; a depth of 2 still needs one bit.
   function automatic int addr_width(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/prog_delay_line_ring_ram.sv
// rtl/prog_delay_line_ring_ram.sv - ring storage: one write port, one registered read port
// A read and a write to the same address in one cycle return the previous content.
module dly_ring_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (re) begin
         rdata_q <= mem_q[raddr];
      end
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/prog_delay_line.sv
// rtl/prog_delay_line.sv - runtime-programmable sample delay (D = dly+1 cycles) over a ring buffer
// Optional clock-enable port ce when PROG_DELAY_LINE_CE_EN is defined.
module prog_delay_line
   import prog_delay_line_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int MAX_DEPTH = DEFAULT_MAX_DEPTH,
   localparam int AW       = addr_width(MAX_DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
`ifdef PROG_DELAY_LINE_CE_EN
   input  logic             ce,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [AW-1:0]    dly,
   output logic [WIDTH-1:0] b,
   output logic             b_valid,
   output logic             busy
);

   logic ce_w;
`ifdef PROG_DELAY_LINE_CE_EN
   assign ce_w = ce;
`else
   assign ce_w = 1'b1;
`endif

   state_e           state_q, state_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    fill_cnt_q, fill_cnt_d;
   logic [AW-1:0]    dly_q, dly_d;
   logic [WIDTH-1:0] byp_q;
   logic             byp_sel_q;
   logic [WIDTH-1:0] ram_rdata;
   logic [AW-1:0]    rd_addr;
   logic             ram_en;

   // FILL ends so that RUN starts exactly D cycles after FLUSH; a zero delay skips FILL.
   always_comb begin
      state_d    = state_q;
      fill_cnt_d = fill_cnt_q;
      dly_d      = dly_q;
      wr_ptr_d   = wr_ptr_q + 1'b1;
      case (state_q)
         FLUSH: begin
            fill_cnt_d = '0;
            state_d    = (dly_q == '0) ? RUN : FILL;
         end
         FILL: begin
            fill_cnt_d = fill_cnt_q + 1'b1;
            if (fill_cnt_d == dly_q) begin
               state_d = RUN;
            end
         end
         RUN: begin
            state_d = RUN;
         end
         default: begin
            state_d = FLUSH;
         end
      endcase
      if (dly != dly_q) begin
         dly_d   = dly;
         state_d = FLUSH;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RST_STATE;
         wr_ptr_q   <= '0;
         fill_cnt_q <= '0;
         dly_q      <= dly;
         byp_q      <= '0;
         byp_sel_q  <= 1'b1;
      end else if (ce_w) begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         fill_cnt_q <= fill_cnt_d;
         dly_q      <= dly_d;
         byp_q      <= a;
         byp_sel_q  <= (dly_q == '0);
      end
   end

   // Slot written dly_q cycles ago; a zero delay would collide with this cycle's write.
   assign rd_addr = wr_ptr_q - dly_q;
   assign ram_en  = ce_w & ~rst;

   dly_ring_ram #(
      .WIDTH (WIDTH),
      .DEPTH (MAX_DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_en),
      .waddr (wr_ptr_q),
      .wdata (a),
      .re    (ram_en),
      .raddr (rd_addr),
      .rdata (ram_rdata)
   );

   assign b       = byp_sel_q ? byp_q : ram_rdata;
   assign b_valid = (state_q == RUN);
   assign busy    = (state_q != RUN);

endmodule

// File: tb/tb_prog_delay_line.sv
// tb/tb_prog_delay_line.sv - randomized self-checking bench for prog_delay_line against a history model
module tb_prog_delay_line;

   localparam int WIDTH     = 8;
   localparam int MAX_DEPTH = 16;
   localparam int AW        = 4;
   localparam int HSIZE     = 1024;

   logic             clk = 1'b0;
   logic             rst;
   logic             ce;
   logic [WIDTH-1:0] a;
   logic [AW-1:0]    dly;
   logic [WIDTH-1:0] b;
   logic             b_valid;
   logic             busy;

   always #5 clk = ~clk;

   prog_delay_line #(
      .WIDTH     (WIDTH),
      .MAX_DEPTH (MAX_DEPTH)
   ) dut (
      .clk     (clk),
      .rst     (rst),
`ifdef PROG_DELAY_LINE_CE_EN
      .ce      (ce),
`endif
      .a       (a),
      .dly     (dly),
      .b       (b),
      .b_valid (b_valid),
      .busy    (busy)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
   endtask

   // Model: every accepted sample goes into a history array; output is valid once
   // D samples have been accepted since the last restart, and then equals a(now-D).
   logic [WIDTH-1:0] hist [HSIZE];
   int               cur       = 0;
   int               d_m       = 1;
   int               since_m   = 0;
   bit               model_on  = 0;
   bit               exp_valid = 0;
   bit               b_known   = 0;
   logic [WIDTH-1:0] exp_b     = '0;

   task automatic model_edge();
      if (rst) begin
         d_m       = int'(dly) + 1;
         since_m   = 0;
         exp_valid = 0;
         exp_b     = '0;
         b_known   = 1;
         model_on  = 1;
      end else if (ce && model_on) begin
         hist[cur % HSIZE] = a;
         cur++;
         if (int'(dly) + 1 != d_m) begin
            d_m     = int'(dly) + 1;
            since_m = 0;
         end else begin
            since_m++;
         end
         exp_valid = (since_m >= d_m);
         b_known   = exp_valid;
         if (exp_valid) exp_b = hist[(cur - d_m) % HSIZE];
      end
   endtask

   always @(negedge clk) begin
      if (model_on) begin
         chk("b_valid", int'(b_valid), int'(exp_valid));
         chk("busy", int'(busy), int'(!exp_valid));
         if (b_known) chk("b", int'(b), int'(exp_b));
      end
   end

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      #1;
   endtask

   // After a reset with dly=3: ramp 1,2,3.. from FLUSH, valid on the 4th edge with b=1.
   task automatic ramp_check();
      for (int i = 1; i <= 8; i++) begin
         a = WIDTH'(i);
         step();
         chk("ramp_valid", int'(b_valid), (i >= 4) ? 1 : 0);
         if (i >= 4) chk("ramp_b", int'(b), i - 3);
      end
   endtask

   // Program a new delay d; valid must drop at once and return d cycles after FLUSH.
   task automatic run_lag(input int d, input int tail);
      logic [WIDTH-1:0] a_flush;
      a_flush = '0;
      dly = AW'(d - 1);
      a   = WIDTH'($urandom);
      step();
      chk("lag_detect_valid", int'(b_valid), 0);
      for (int k = 1; k <= d + tail; k++) begin
         a = WIDTH'($urandom);
         if (k == 1) a_flush = a;
         step();
         if (k == d - 1) chk("lag_early_valid", int'(b_valid), 0);
         if (k == d) begin
            chk("lag_first_valid", int'(b_valid), 1);
            chk("lag_first_b", int'(b), int'(a_flush));
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      ce  = 1'b1;
      a   = '0;
      dly = AW'(3);
      step();
      chk("reset_b", int'(b), 0);
      chk("reset_valid", int'(b_valid), 0);
      chk("reset_busy", int'(busy), 1);
      rst = 1'b0;
      ramp_check();

      run_lag(1, 20);
      run_lag(16, 40);
      run_lag(4, 6);
      run_lag(8, 12);

      // Restart in the middle of FILL: dly 2 -> 5 while fill_cnt is 1.
      dly = AW'(2);
      a   = WIDTH'($urandom);
      step();
      a = WIDTH'($urandom);
      step();
      a = WIDTH'($urandom);
      step();
      chk("midfill_busy", int'(busy), 1);
      run_lag(6, 10);

      // One-cycle reset during RUN, then refill as after power-up.
      rst = 1'b1;
      dly = AW'(3);
      step();
      chk("rerst_b", int'(b), 0);
      chk("rerst_valid", int'(b_valid), 0);
      chk("rerst_busy", int'(busy), 1);
      rst = 1'b0;
      ramp_check();

      for (int i = 0; i < 400; i++) begin
         a = WIDTH'($urandom);
         if ($urandom_range(0, 19) == 0) dly = AW'($urandom);
         rst = ($urandom_range(0, 79) == 0);
`ifdef PROG_DELAY_LINE_CE_EN
         ce = ($urandom_range(0, 3) != 0);
`endif
         step();
      end
      rst = 1'b0;
      ce  = 1'b1;

`ifdef PROG_DELAY_LINE_CE_EN
      rst = 1'b1;
      dly = AW'(2);
      step();
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         ce = (i % 2 == 0);
         a  = WIDTH'($urandom);
         step();
      end
      ce = 1'b1;
`endif

      for (int i = 0; i < 20; i++) begin
         a = WIDTH'($urandom);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
